// File: rtl/branch_rob.sv
// Branch reorder buffer: a circular buffer of in-flight branches. Dispatch
// allocates at the tail, the branch unit writes resolution results back by
// index, and the ROB retires entries in order from the head. Each retired
// entry is reported to the branch predictor one cycle later as a registered
// pulse.
//
// Optional feature: define BROB_PERF_CNT_EN to add o_mispred_cnt, a
// saturating 32-bit count of committed mispredicted branches.
module branch_rob #(
   parameter int DEPTH = 16,
   parameter int IDXW  = $clog2(DEPTH),
   parameter int FSQW  = 4,
   parameter int XLEN  = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_alloc_vld,
   input  logic [2:0]               i_alloc_type,
   input  logic [FSQW-1:0]          i_alloc_fsq_idx,
   input  logic                     i_alloc_eob,
   output logic                     o_alloc_rdy,
   output logic [IDXW-1:0]          o_alloc_idx,
   input  logic                     i_wb_vld,
   input  logic [IDXW-1:0]          i_wb_idx,
   input  logic                     i_wb_taken,
   input  logic                     i_wb_mispred,
   input  logic [XLEN-1:0]          i_wb_npc,
   input  logic                     i_commit_vld,
   output logic                     o_head_done,
   output logic                     o_commit_vld,
   output logic [2:0]               o_commit_type,
   output logic [FSQW-1:0]          o_commit_fsq_idx,
   output logic                     o_commit_eob,
   output logic                     o_commit_taken,
   output logic [XLEN-1:0]          o_commit_npc,
   output logic                     o_commit_mispred,
   input  logic                     i_squash
`ifdef BROB_PERF_CNT_EN
   ,
   output logic [31:0]              o_mispred_cnt
`endif
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   localparam int PTRW = IDXW + 1;

   logic [PTRW-1:0]  head_q, head_d;
   logic [PTRW-1:0]  tail_q, tail_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] done_q, done_d;

   logic [2:0]       type_q    [DEPTH];
   logic [FSQW-1:0]  fsq_q     [DEPTH];
   logic             eob_q     [DEPTH];
   logic             taken_q   [DEPTH];
   logic             mispred_q [DEPTH];
   logic [XLEN-1:0]  npc_q     [DEPTH];

   logic             cvld_q;
   logic [2:0]       ctype_q;
   logic [FSQW-1:0]  cfsq_q;
   logic             ceob_q;
   logic             ctaken_q;
   logic [XLEN-1:0]  cnpc_q;
   logic             cmispred_q;

   logic [IDXW-1:0]  head_idx;
   logic [IDXW-1:0]  tail_idx;
   logic             full;
   logic             alloc_fire;
   logic             wb_hit;
   logic             commit_fire;

   assign head_idx    = head_q[IDXW-1:0];
   assign tail_idx    = tail_q[IDXW-1:0];
   // Same slot but opposite lap means every entry is occupied.
   assign full        = (head_idx == tail_idx) && (head_q[IDXW] != tail_q[IDXW]);
   assign o_alloc_rdy = ~full;
   assign o_alloc_idx = tail_idx;
   assign o_head_done = valid_q[head_idx] & done_q[head_idx];

   assign alloc_fire  = i_alloc_vld & ~full;
   // A writeback only lands on an entry that is live before this edge.
   assign wb_hit      = i_wb_vld & valid_q[i_wb_idx];
   // done is read from registered state, so a same-cycle writeback to the
   // head cannot make it retire this cycle.
   assign commit_fire = i_commit_vld & o_head_done;

   // Next-state for pointers and per-entry valid/done; squash overrides all.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (wb_hit) begin
         done_d[i_wb_idx] = 1'b1;
      end
      if (commit_fire) begin
         valid_d[head_idx] = 1'b0;
         done_d[head_idx]  = 1'b0;
         head_d            = head_q + PTRW'(1);
      end
      if (alloc_fire) begin
         valid_d[tail_idx] = 1'b1;
         done_d[tail_idx]  = 1'b0;
         tail_d            = tail_q + PTRW'(1);
      end
      if (i_squash) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Entry payload storage; contents are only meaningful while valid.
   always_ff @(posedge clk) begin
      if (alloc_fire && !i_squash) begin
         type_q[tail_idx] <= i_alloc_type;
         fsq_q[tail_idx]  <= i_alloc_fsq_idx;
         eob_q[tail_idx]  <= i_alloc_eob;
      end
      if (wb_hit && !i_squash) begin
         taken_q[i_wb_idx]   <= i_wb_taken;
         mispred_q[i_wb_idx] <= i_wb_mispred;
         npc_q[i_wb_idx]     <= i_wb_npc;
      end
   end

   // Registered commit report; a squash in the same cycle does not suppress it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cvld_q     <= 1'b0;
         ctype_q    <= '0;
         cfsq_q     <= '0;
         ceob_q     <= 1'b0;
         ctaken_q   <= 1'b0;
         cnpc_q     <= '0;
         cmispred_q <= 1'b0;
      end else begin
         cvld_q <= commit_fire;
         if (commit_fire) begin
            ctype_q    <= type_q[head_idx];
            cfsq_q     <= fsq_q[head_idx];
            ceob_q     <= eob_q[head_idx];
            ctaken_q   <= taken_q[head_idx];
            cnpc_q     <= npc_q[head_idx];
            cmispred_q <= mispred_q[head_idx];
         end
      end
   end

   assign o_commit_vld     = cvld_q;
   assign o_commit_type    = ctype_q;
   assign o_commit_fsq_idx = cfsq_q;
   assign o_commit_eob     = ceob_q;
   assign o_commit_taken   = ctaken_q;
   assign o_commit_npc     = cnpc_q;
   assign o_commit_mispred = cmispred_q;

`ifdef BROB_PERF_CNT_EN
   logic [31:0] mcnt_q;

   // Saturating count of committed mispredictions; survives squash.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcnt_q <= '0;
      end else if (commit_fire && mispred_q[head_idx] && (mcnt_q != '1)) begin
         mcnt_q <= mcnt_q + 32'd1;
      end
   end

   assign o_mispred_cnt = mcnt_q;
`endif

endmodule

// File: tb/tb_branch_rob.sv
// Bench for branch_rob: directed scenarios followed by random traffic, all
// checked against an age-ordered queue model of the live branches.
module tb_branch_rob;
   localparam int DEPTH = 16;
   localparam int IDXW  = 4;
   localparam int FSQW  = 4;
   localparam int XLEN  = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            i_alloc_vld;
   logic [2:0]      i_alloc_type;
   logic [FSQW-1:0] i_alloc_fsq_idx;
   logic            i_alloc_eob;
   logic            o_alloc_rdy;
   logic [IDXW-1:0] o_alloc_idx;
   logic            i_wb_vld;
   logic [IDXW-1:0] i_wb_idx;
   logic            i_wb_taken;
   logic            i_wb_mispred;
   logic [XLEN-1:0] i_wb_npc;
   logic            i_commit_vld;
   logic            o_head_done;
   logic            o_commit_vld;
   logic [2:0]      o_commit_type;
   logic [FSQW-1:0] o_commit_fsq_idx;
   logic            o_commit_eob;
   logic            o_commit_taken;
   logic [XLEN-1:0] o_commit_npc;
   logic            o_commit_mispred;
   logic            i_squash;
`ifdef BROB_PERF_CNT_EN
   logic [31:0]     o_mispred_cnt;
`endif

   branch_rob #(.DEPTH(DEPTH), .IDXW(IDXW), .FSQW(FSQW), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .i_alloc_vld(i_alloc_vld), .i_alloc_type(i_alloc_type),
      .i_alloc_fsq_idx(i_alloc_fsq_idx), .i_alloc_eob(i_alloc_eob),
      .o_alloc_rdy(o_alloc_rdy), .o_alloc_idx(o_alloc_idx),
      .i_wb_vld(i_wb_vld), .i_wb_idx(i_wb_idx), .i_wb_taken(i_wb_taken),
      .i_wb_mispred(i_wb_mispred), .i_wb_npc(i_wb_npc),
      .i_commit_vld(i_commit_vld), .o_head_done(o_head_done),
      .o_commit_vld(o_commit_vld), .o_commit_type(o_commit_type),
      .o_commit_fsq_idx(o_commit_fsq_idx), .o_commit_eob(o_commit_eob),
      .o_commit_taken(o_commit_taken), .o_commit_npc(o_commit_npc),
      .o_commit_mispred(o_commit_mispred),
      .i_squash(i_squash)
`ifdef BROB_PERF_CNT_EN
      , .o_mispred_cnt(o_mispred_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [2:0]  typ;
      logic [3:0]  fsq;
      logic        eob;
      logic        done;
      logic        taken;
      logic        mispred;
      logic [63:0] npc;
   } ent_t;

   ent_t q[$];        // live branches, oldest first
   int   tail_cnt;    // slot the next allocation receives
   longint exp_cnt;   // expected mispredict count
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      i_alloc_vld = 0; i_alloc_type = 0; i_alloc_fsq_idx = 0; i_alloc_eob = 0;
      i_wb_vld = 0; i_wb_idx = 0; i_wb_taken = 0; i_wb_mispred = 0; i_wb_npc = 0;
      i_commit_vld = 0; i_squash = 0;
   endtask

   // One clock with the currently driven inputs; called at posedge+1.
   task automatic step();
      logic cfire;
      logic room;
      ent_t ce;
      ent_t e;
      check("alloc_rdy", o_alloc_rdy, q.size() < DEPTH);
      check("alloc_idx", o_alloc_idx, tail_cnt);
      check("head_done", o_head_done, (q.size() > 0) && q[0].done);
      cfire = i_commit_vld && (q.size() > 0) && q[0].done;
      if (cfire) ce = q[0];
      room = q.size() < DEPTH;
      if (i_squash) begin
         q.delete();
         tail_cnt = 0;
      end else begin
         if (i_wb_vld) begin
            for (int k = 0; k < q.size(); k++) begin
               if (q[k].idx == int'(i_wb_idx)) begin
                  e = q[k];
                  e.done = 1; e.taken = i_wb_taken; e.mispred = i_wb_mispred; e.npc = i_wb_npc;
                  q[k] = e;
               end
            end
         end
         if (cfire) void'(q.pop_front());
         if (i_alloc_vld && room) begin
            e.idx = tail_cnt; e.typ = i_alloc_type; e.fsq = i_alloc_fsq_idx;
            e.eob = i_alloc_eob; e.done = 0; e.taken = 0; e.mispred = 0; e.npc = 0;
            q.push_back(e);
            tail_cnt = (tail_cnt + 1) % DEPTH;
         end
      end
      if (cfire && ce.mispred && exp_cnt < 64'hffff_ffff) exp_cnt++;
      @(posedge clk);
      #1;
      check("commit_vld", o_commit_vld, cfire);
      if (cfire) begin
         check("commit_type", o_commit_type, ce.typ);
         check("commit_fsq", o_commit_fsq_idx, ce.fsq);
         check("commit_eob", o_commit_eob, ce.eob);
         check("commit_taken", o_commit_taken, ce.taken);
         check("commit_mispred", o_commit_mispred, ce.mispred);
         check("commit_npc", o_commit_npc, ce.npc);
      end
`ifdef BROB_PERF_CNT_EN
      check("mispred_cnt", o_mispred_cnt, exp_cnt);
`endif
      idle();
   endtask

   // Asserts reset right now (between edges) and checks the asynchronous clear.
   task automatic do_reset();
      idle();
      rst = 0;
      #1;
      check("rst_commit_vld", o_commit_vld, 0);
      check("rst_commit_npc", o_commit_npc, 0);
      check("rst_commit_fsq", o_commit_fsq_idx, 0);
      check("rst_alloc_rdy", o_alloc_rdy, 1);
      check("rst_alloc_idx", o_alloc_idx, 0);
      check("rst_head_done", o_head_done, 0);
`ifdef BROB_PERF_CNT_EN
      check("rst_mispred_cnt", o_mispred_cnt, 0);
`endif
      q.delete();
      tail_cnt = 0;
      exp_cnt = 0;
      @(posedge clk);
      #3 rst = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic alloc(input logic [2:0] t, input logic [3:0] f, input logic eob);
      i_alloc_vld = 1; i_alloc_type = t; i_alloc_fsq_idx = f; i_alloc_eob = eob;
   endtask

   task automatic wb(input int idx, input logic tk, input logic mp, input logic [63:0] npc);
      i_wb_vld = 1; i_wb_idx = IDXW'(idx); i_wb_taken = tk; i_wb_mispred = mp; i_wb_npc = npc;
   endtask

   initial begin
      idle();
      q.delete();
      tail_cnt = 0;
      exp_cnt = 0;
      #1;
      do_reset();

      // Fill all 16 slots, then a 17th request is dropped.
      for (int i = 0; i < DEPTH; i++) begin
         alloc(3'(i), 4'(i), i[0]);
         step();
      end
      alloc(3'd1, 4'd9, 1'b0);
      step();
      step();

      // Full buffer: alloc+commit together -> commit emitted, alloc dropped.
      wb(0, 1, 0, 64'h1234);
      step();
      alloc(3'd2, 4'd2, 1'b1);
      i_commit_vld = 1;
      step();
      step();

      // Single-entry flow with known values.
      do_reset();
      alloc(3'd0, 4'd3, 1'b0);
      step();
      wb(0, 1, 0, 64'h0000_0000_8000_0040);
      step();
      i_commit_vld = 1;
      step();
      step();

      // Commit before writeback is ignored; then wb, commit; then same-cycle wb+commit.
      alloc(3'd4, 4'd5, 1'b1);
      step();
      i_commit_vld = 1;
      step();
      wb(1, 0, 1, 64'hdead_beef_0000_0010);
      step();
      i_commit_vld = 1;
      step();
      alloc(3'd5, 4'd6, 1'b0);
      step();
      wb(2, 1, 1, 64'h55);
      i_commit_vld = 1;
      step();
      i_commit_vld = 1;
      step();
      step();

      // Five live entries, squash with concurrent commit and alloc.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         alloc(3'd3, 4'(i + 8), 1'b0);
         step();
      end
      wb(0, 0, 1, 64'h77);
      step();
      i_commit_vld = 1;
      i_squash = 1;
      alloc(3'd1, 4'd1, 1'b1);
      wb(1, 1, 0, 64'h88);
      step();
      wb(2, 1, 1, 64'h99);
      step();
      i_commit_vld = 1;
      step();

      // Three mispredicted commits, a squash, then reset clears the count.
      for (int i = 0; i < 3; i++) begin
         alloc(3'd2, 4'(i), 1'b0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         wb(i, 1, 1, 64'(100 + i));
         step();
      end
      for (int i = 0; i < 3; i++) begin
         i_commit_vld = 1;
         step();
      end
      alloc(3'd0, 4'd0, 1'b0);
      step();
      i_squash = 1;
      step();
      step();

      // Reset mid-operation while a commit is pending: no pulse follows.
      alloc(3'd6, 4'd7, 1'b1);
      step();
      wb(0, 1, 0, 64'h42);
      step();
      i_commit_vld = 1;
      do_reset();
      check("post_rst_commit_vld", o_commit_vld, 0);
      step();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         i_alloc_vld = ($urandom_range(0, 99) < 55);
         i_alloc_type = 3'($urandom);
         i_alloc_fsq_idx = 4'($urandom);
         i_alloc_eob = 1'($urandom);
         i_wb_vld = ($urandom_range(0, 99) < 50);
         if (q.size() > 0 && $urandom_range(0, 3) != 0)
            i_wb_idx = IDXW'(q[$urandom_range(0, q.size() - 1)].idx);
         else
            i_wb_idx = IDXW'($urandom);
         i_wb_taken = 1'($urandom);
         i_wb_mispred = 1'($urandom);
         i_wb_npc = {$urandom, $urandom};
         i_commit_vld = ($urandom_range(0, 99) < 45);
         i_squash = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/branch_rob.md
BRANCH_ROB -- requirements
Module: branch_rob

Interface
REQ-001 Parameter DEPTH, 16, number of branch entries; SHALL be a power of two, at least 4.
REQ-002 Parameter IDXW, $clog2(DEPTH), entry index width (brob index).
REQ-003 Parameter FSQW, 4, fetch-target-queue index width.
REQ-004 Parameter XLEN, 64, PC width.
REQ-005 clk  in  1  core clock; all state on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 i_alloc_vld  in  1  dispatch requests one branch entry.
REQ-008 i_alloc_type  in  3  BranchType encoding (isCond..isRet).
REQ-009 i_alloc_fsq_idx  in  FSQW  fetch-target-queue index of the branch.
REQ-010 i_alloc_eob  in  1  branch ends its fetch block.
REQ-011 o_alloc_rdy  out  1  at least one entry free.
REQ-012 o_alloc_idx  out  IDXW  index granted to the current alloc (tail pointer).
REQ-013 i_wb_vld  in  1  BRU writeback valid.
REQ-014 i_wb_idx  in  IDXW  brob index being written back.
REQ-015 i_wb_taken, i_wb_mispred  in  1 each  actual direction; misprediction flag.
REQ-016 i_wb_npc  in  XLEN  resolved target PC.
REQ-017 i_commit_vld  in  1  ROB retires the oldest branch.
REQ-018 o_head_done  out  1  head entry valid and written back.
REQ-019 o_commit_vld  out  1  branch commit info valid to BPU.
REQ-020 o_commit_type, o_commit_fsq_idx, o_commit_eob, o_commit_taken, o_commit_npc, o_commit_mispred  out  3/FSQW/1/1/XLEN/1  registered head-entry fields.
REQ-021 i_squash  in  1  pipeline squash; flush all entries.

Function
REQ-022 Storage SHALL be a circular buffer; head/tail pointers IDXW bits plus one wrap bit each.
REQ-023 o_alloc_rdy SHALL be 1 iff occupancy < DEPTH; it SHALL be derived from registered state only.
REQ-024 Alloc with o_alloc_vld & o_alloc_rdy SHALL write the entry at tail, clear its done bit, set its valid bit, and advance tail by one (modulo DEPTH, toggling wrap).
REQ-025 Alloc when o_alloc_rdy=0 SHALL be dropped with no state change.
REQ-026 Writeback SHALL set done and store taken/mispred/npc at i_wb_idx; writeback to an invalid entry SHALL be ignored.
REQ-027 o_head_done SHALL be combinational: valid[head] & done[head].
REQ-028 i_commit_vld with o_head_done=1 SHALL free head, advance head, and drive o_commit_* with the head fields exactly one cycle later.
REQ-029 i_commit_vld with o_head_done=0 SHALL be ignored; o_commit_vld SHALL stay 0.
REQ-030 o_commit_vld SHALL be a single-cycle pulse per committed entry.
REQ-031 Alloc and commit in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-032 A writeback and commit to the head in the same cycle SHALL NOT commit (done is not bypassed).
REQ-033 i_squash SHALL take priority over alloc and writeback in the same cycle; commit in that cycle SHALL still emit its o_commit_* pulse.
REQ-034 After i_squash, the next cycle SHALL show all valid bits 0, head=tail=0, and o_alloc_rdy=1.

Reset
REQ-035 On rst low, the following SHALL clear immediately, independent of clk: all valid/done bits, pointers, o_commit_vld, and all o_commit_* data (0).
REQ-036 After reset: o_alloc_rdy=1, o_alloc_idx=0, o_head_done=0.
REQ-037 Reset asserted mid-operation SHALL discard all entries; no commit pulse SHALL follow.

Configuration
REQ-038 Macro BROB_PERF_CNT_EN: when defined, the module SHALL add output o_mispred_cnt (32 bits). The counter increments on each emitted commit with mispred=1, saturates at all-ones, resets to 0, and is not cleared by squash.
REQ-039 When BROB_PERF_CNT_EN is undefined, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-040 Scenario: reset, then 16 allocs -> o_alloc_idx 0..15, then o_alloc_rdy=0; a 17th alloc is dropped.
REQ-041 Scenario: alloc idx0 (type isCond, fsq 3), wb idx0 taken=1 npc=0x8000_0040, commit -> next cycle o_commit_vld=1, fsq 3, taken=1, npc=0x8000_0040.
REQ-042 Scenario: commit with the head not written back -> no pulse; writeback then commit -> pulse; same-cycle wb+commit -> no pulse.
REQ-043 Scenario: full buffer with alloc+commit in the same cycle -> the commit pulse is emitted and the alloc is dropped (rdy was 0).
REQ-044 Scenario: 5 entries live, squash with a concurrent commit -> one commit pulse, then head=tail=0 and rdy=1; a later wb to an old index is ignored.
REQ-045 Scenario: with BROB_PERF_CNT_EN defined, commit 3 entries with mispred=1 -> o_mispred_cnt=3; the count stays 3 after a squash and is 0 after reset.
